// File: rtl/cond_logic.sv
// Conditional-execution stage: holds the NZCV flags, evaluates the condition
// field against them, gates the write strobes and counts squashed instructions.
module cond_logic #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             instr_valid,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   output logic             CondEx,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] squash_cnt
);

   logic [3:0]       flags_q, flags_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             n_flag, z_flag, c_flag, v_flag;
   logic             cond_ex;

   assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

   // Evaluated against registered flags only, so an instruction never sees its own result.
   always_comb begin
      cond_ex = 1'b0;
      case (Cond)
         4'b0000: cond_ex = z_flag;
         4'b0001: cond_ex = ~z_flag;
         4'b0010: cond_ex = c_flag;
         4'b0011: cond_ex = ~c_flag;
         4'b0100: cond_ex = n_flag;
         4'b0101: cond_ex = ~n_flag;
         4'b0110: cond_ex = v_flag;
         4'b0111: cond_ex = ~v_flag;
         4'b1000: cond_ex = c_flag & ~z_flag;
         4'b1001: cond_ex = ~c_flag | z_flag;
         4'b1010: cond_ex = (n_flag == v_flag);
         4'b1011: cond_ex = (n_flag != v_flag);
         4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
         4'b1101: cond_ex = z_flag | (n_flag != v_flag);
         default: cond_ex = 1'b1;
      endcase
   end

   always_comb begin
      flags_d = flags_q;
      cnt_d   = cnt_q;
      if (en) begin
         if (FlagW[1] && cond_ex) flags_d[3:2] = ALUFlags[3:2];
         if (FlagW[0] && cond_ex) flags_d[1:0] = ALUFlags[1:0];
         if (instr_valid && !cond_ex && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= 4'b0000;
         cnt_q   <= '0;
      end else begin
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
      end
   end

   assign CondEx     = cond_ex;
   assign PCSrc      = ~rst & PCS & cond_ex;
   assign RegWrite   = ~rst & RegW & cond_ex & ~NoWrite;
   assign MemWrite   = ~rst & MemW & cond_ex;
   assign Flags      = flags_q;
   assign squash_cnt = cnt_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic: reset, flag update/latency, partial updates,
// squash counting with saturation, stall, and a full Cond x Flags sweep.
module tb_cond_logic;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst, en, instr_valid;
   logic [3:0]       Cond, ALUFlags;
   logic [1:0]       FlagW;
   logic             PCS, RegW, MemW, NoWrite;
   logic             CondEx, PCSrc, RegWrite, MemWrite;
   logic [3:0]       Flags;
   logic [CNT_W-1:0] squash_cnt;

   int checks_cnt = 0;
   int fail_cnt   = 0;

   cond_logic #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .en(en), .instr_valid(instr_valid),
      .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
      .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
      .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .Flags(Flags), .squash_cnt(squash_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pairs of conditions are complements, except code 1111 which is always true.
   function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, base;
      {n, z, cf, v} = f;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf && !z;
         3'd5: base = (n ~^ v);
         3'd6: base = !z && (n ~^ v);
         default: base = 1'b1;
      endcase
      if (c == 4'b1111) return 1'b1;
      return c[0] ? !base : base;
   endfunction

   initial begin
      rst = 1'b1; en = 1'b0; instr_valid = 1'b0; Cond = 4'hE; ALUFlags = 4'h0;
      FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
      tick(); tick();

      // reset forces strobes low but CondEx still evaluates
      PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; #1;
      check_val("rst_pcsrc", PCSrc, 0);
      check_val("rst_regwrite", RegWrite, 0);
      check_val("rst_memwrite", MemWrite, 0);
      check_val("rst_condex", CondEx, 1);
      check_val("rst_flags", Flags, 0);
      check_val("rst_cnt", squash_cnt, 0);
      rst = 1'b0; #1;
      check_val("al_pcsrc", PCSrc, 1);
      check_val("al_regwrite", RegWrite, 1);
      check_val("al_memwrite", MemWrite, 1);
      $display("T1 reset/AL strobes done");

      // flag update with 1-cycle latency
      PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
      en = 1'b1; FlagW = 2'b11; Cond = 4'hE; ALUFlags = 4'h4;
      check_val("latency_flags_pre", Flags, 0);
      tick();
      FlagW = 2'b00; Cond = 4'h0; #1;
      check_val("eq_condex", CondEx, 1);
      check_val("upd_flags", Flags, 4'h4);
      Cond = 4'h1; #1;
      check_val("ne_condex", CondEx, 0);
      $display("T2 flag update latency done");

      // partial update: only C,V
      FlagW = 2'b01; Cond = 4'hE; ALUFlags = 4'hB;
      tick();
      FlagW = 2'b00;
      check_val("partial_flags", Flags, 4'h7);
      Cond = 4'h8; #1;
      check_val("hi_condex", CondEx, 0);
      Cond = 4'hA; #1;
      check_val("ge_condex", CondEx, 0);
      FlagW = 2'b10; Cond = 4'hE; ALUFlags = 4'h8;
      tick();
      check_val("partial_nz_flags", Flags, 4'hB);
      $display("T3 partial update done");

      // failed condition: flags hold, strobe gated, counter increments
      FlagW = 2'b11; Cond = 4'hE; ALUFlags = 4'h0;
      tick();
      Cond = 4'h0; ALUFlags = 4'hF; PCS = 1'b1; instr_valid = 1'b1; #1;
      check_val("fail_pcsrc", PCSrc, 0);
      tick();
      check_val("fail_flags", Flags, 0);
      check_val("fail_cnt", squash_cnt, 1);
      PCS = 1'b0;
      $display("T4 failed condition done");

      // stall holds flags and counter
      en = 1'b0; Cond = 4'hE; ALUFlags = 4'hA;
      repeat (5) tick();
      Cond = 4'h0;
      repeat (3) tick();
      check_val("stall_flags", Flags, 0);
      check_val("stall_cnt", squash_cnt, 1);
      Cond = 4'hE; en = 1'b1;
      tick();
      check_val("unstall_flags", Flags, 4'hA);
      check_val("unstall_cnt", squash_cnt, 1);
      $display("T5 stall done");

      // NoWrite gating
      instr_valid = 1'b0; FlagW = 2'b00; RegW = 1'b1; NoWrite = 1'b1; #1;
      check_val("nowrite_regwrite", RegWrite, 0);
      check_val("nowrite_condex", CondEx, 1);
      NoWrite = 1'b0; #1;
      check_val("write_regwrite", RegWrite, 1);
      RegW = 1'b0;
      $display("T6 NoWrite done");

      // reset mid-stream discards a pending flag write and clears the counter
      rst = 1'b1; FlagW = 2'b11; ALUFlags = 4'hF; instr_valid = 1'b1; Cond = 4'h0;
      tick();
      check_val("midrst_flags", Flags, 0);
      check_val("midrst_cnt", squash_cnt, 0);
      rst = 1'b0; instr_valid = 1'b0;

      // full sweep of conditions over every flag value
      for (int f = 0; f < 16; f++) begin
         FlagW = 2'b11; Cond = 4'hE; ALUFlags = 4'(f);
         tick();
         FlagW = 2'b00;
         check_val("sweep_flags", Flags, 32'(f));
         for (int c = 0; c < 16; c++) begin
            Cond = 4'(c); #1;
            check_val($sformatf("sweep_c%0h_f%0h", c, f), CondEx, ref_cond(4'(c), 4'(f)));
         end
      end
      $display("T7 cond sweep done");

      // saturation: flags are now 1111, NE fails
      Cond = 4'h1; instr_valid = 1'b1; FlagW = 2'b00;
      for (int i = 0; i < 20; i++) begin
         tick();
         check_val($sformatf("sat_cnt_%0d", i), squash_cnt, (i + 1 > 15) ? 15 : i + 1);
      end
      tick();
      check_val("sat_hold", squash_cnt, 15);
      $display("T8 saturation done");

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
